hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/multicore_pkg.sv | 34 +++
 rtl/hz_scoreboard.sv | 39 +++
 rtl/hazard_controller.sv | 95 +++++++++
 tb/tb_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types and helpers for the pipeline hazard controller and its scoreboard.
package multicore_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FREEZE = 2'd2,
    HZ_REDIR  = 2'd3
  } t_hz_state;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MA   = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } t_sb_entry;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic rd_match(t_sb_entry e, logic [4:0] rs);
    return e.valid && e.regwrite && (e.rd == rs) && (rs != 5'd0);
  endfunction

  // A load in MA has no data yet, so only an ALU result may forward from MA.
  function automatic logic [1:0] fwd_sel(t_sb_entry ma, t_sb_entry wb, logic [4:0] rs);
    if (rd_match(ma, rs) && !ma.load) return FWD_MA;
    if (rd_match(wb, rs))             return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Shadow copy of the destination info held in EX, MA and WB.
module hz_scoreboard
  import multicore_pkg::*;
(
  input  logic      i_aclk,
  input  logic      i_areset_n,
  input  logic      i_hold,
  input  logic      i_bubble,
  input  t_sb_entry i_id_entry,
  output t_sb_entry o_ex,
  output t_sb_entry o_ma,
  output t_sb_entry o_wb
);

  t_sb_entry r_ex, r_ma, r_wb;
  t_sb_entry w_ex_next;

  always_comb begin
    w_ex_next       = i_id_entry;
    w_ex_next.valid = i_id_entry.valid & ~i_bubble;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_ex <= '0;
      r_ma <= '0;
      r_wb <= '0;
    end else if (!i_hold) begin
      r_wb <= r_ma;
      r_ma <= r_ex;
      r_ex <= w_ex_next;
    end
  end

  assign o_ex = r_ex;
  assign o_ma = r_ma;
  assign o_wb = r_wb;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stall/freeze/redirect sequencing plus forwarding selects.
// Handshake: none; enables and flushes are level signals valid in the same cycle as the decode fields.
module hazard_controller
  import multicore_pkg::*;
(
  input  logic        i_aclk,
  input  logic        i_areset_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_id_rdest,
  input  logic        i_id_regwrite,
  input  logic        i_id_load,
  input  logic        i_id_jal,
  input  logic        i_ex_redirect,
  input  logic        i_dmem_busy,
  output logic        o_if_en,
  output logic        o_id_en,
  output logic        o_id_flush,
  output logic        o_ex_flush,
  output logic [1:0]  o_forward_a,
  output logic [1:0]  o_forward_b,
  output t_hz_state   o_state,
  output logic [15:0] o_stall_cycles
);

  t_hz_state   r_state, w_next_state;
  t_sb_entry   w_ex, w_ma, w_wb, w_id_entry;
  logic        w_redir_shadow, w_ex_hit, w_ma_load_hit, w_hazard;
  logic [15:0] r_stall_cycles;

  // The cycle after a redirect, decode holds a NOP, so its fields are ignored.
  assign w_redir_shadow = (r_state == HZ_REDIR);
  assign w_id_entry     = '{valid: 1'b1, rd: i_id_rdest, regwrite: i_id_regwrite, load: i_id_load};
  assign w_ex_hit       = rd_match(w_ex, i_id_rs1) | rd_match(w_ex, i_id_rs2);
  assign w_ma_load_hit  = w_ma.load & (rd_match(w_ma, i_id_rs1) | rd_match(w_ma, i_id_rs2));
  assign w_hazard       = ~w_redir_shadow & (w_ex_hit | w_ma_load_hit);

  assign o_forward_a = fwd_sel(w_ma, w_wb, i_id_rs1);
  assign o_forward_b = fwd_sel(w_ma, w_wb, i_id_rs2);

  always_comb begin
    w_next_state = HZ_RUN;
    o_if_en      = 1'b1;
    o_id_en      = 1'b1;
    o_id_flush   = 1'b0;
    o_ex_flush   = 1'b0;
    if (!i_areset_n) begin
      w_next_state = HZ_RUN;
    end else if (i_dmem_busy) begin
      w_next_state = HZ_FREEZE;
      o_if_en      = 1'b0;
      o_id_en      = 1'b0;
    end else if (i_ex_redirect) begin
      w_next_state = HZ_REDIR;
      o_id_flush   = 1'b1;
      o_ex_flush   = 1'b1;
    end else if (w_hazard) begin
      w_next_state = HZ_STALL;
      o_if_en      = 1'b0;
      o_id_en      = 1'b0;
      o_ex_flush   = 1'b1;
    end else begin
      o_id_flush   = i_id_jal & ~w_redir_shadow;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) r_state <= HZ_RUN;
    else             r_state <= w_next_state;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_stall_cycles <= 16'd0;
    end else if ((w_next_state == HZ_STALL || w_next_state == HZ_FREEZE) &&
                 r_stall_cycles != 16'hFFFF) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  hz_scoreboard u_scoreboard (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_hold     (w_next_state == HZ_FREEZE),
    .i_bubble   (o_ex_flush),
    .i_id_entry (w_id_entry),
    .o_ex       (w_ex),
    .o_ma       (w_ma),
    .o_wb       (w_wb)
  );

  assign o_state        = r_state;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: pipeline-level reference model plus directed scenarios.
module tb_hazard_controller;
  import multicore_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rw = 1'b0, id_ld = 1'b0, id_jal = 1'b0, ex_redir = 1'b0, dmem_busy = 1'b0;
  logic        o_if_en, o_id_en, o_id_flush, o_ex_flush;
  logic [1:0]  o_forward_a, o_forward_b;
  t_hz_state   o_state;
  logic [15:0] o_stall_cycles;

  hazard_controller dut (
    .i_aclk         (clk),
    .i_areset_n     (rst_n),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_rdest     (id_rd),
    .i_id_regwrite  (id_rw),
    .i_id_load      (id_ld),
    .i_id_jal       (id_jal),
    .i_ex_redirect  (ex_redir),
    .i_dmem_busy    (dmem_busy),
    .o_if_en        (o_if_en),
    .o_id_en        (o_id_en),
    .o_id_flush     (o_id_flush),
    .o_ex_flush     (o_ex_flush),
    .o_forward_a    (o_forward_a),
    .o_forward_b    (o_forward_b),
    .o_state        (o_state),
    .o_stall_cycles (o_stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stages 0=EX 1=MA 2=WB) ----------------
  t_hz_state  m_state;
  logic       m_v[3];
  logic [4:0] m_rd[3];
  logic       m_rw[3];
  logic       m_ld[3];
  int         m_cnt;
  t_hz_state  e_cond;
  logic       e_if, e_id, e_idf, e_exf;
  logic [1:0] e_fa, e_fb;

  function automatic logic m_hit(int s, logic [4:0] rs);
    return m_v[s] && m_rw[s] && (m_rd[s] == rs) && (rs != 5'd0);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] rs);
    if (m_hit(1, rs) && !m_ld[1]) return 2'b01;
    if (m_hit(2, rs)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_state = HZ_RUN;
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0; m_rd[i] = '0; m_rw[i] = 1'b0; m_ld[i] = 1'b0;
    end
  endtask

  task automatic model_eval();
    logic haz;
    haz = m_hit(0, id_rs1) || m_hit(0, id_rs2) ||
          (m_ld[1] && (m_hit(1, id_rs1) || m_hit(1, id_rs2)));
    if (m_state == HZ_REDIR) haz = 1'b0;
    e_fa = m_fwd(id_rs1);
    e_fb = m_fwd(id_rs2);
    if (!rst_n) begin
      e_cond = HZ_RUN; e_if = 1; e_id = 1; e_idf = 0; e_exf = 0;
    end else if (dmem_busy) begin
      e_cond = HZ_FREEZE; e_if = 0; e_id = 0; e_idf = 0; e_exf = 0;
    end else if (ex_redir) begin
      e_cond = HZ_REDIR; e_if = 1; e_id = 1; e_idf = 1; e_exf = 1;
    end else if (haz) begin
      e_cond = HZ_STALL; e_if = 0; e_id = 0; e_idf = 0; e_exf = 1;
    end else begin
      e_cond = HZ_RUN; e_if = 1; e_id = 1; e_exf = 0;
      e_idf = id_jal && (m_state != HZ_REDIR);
    end
  endtask

  task automatic model_commit();
    if (e_cond != HZ_FREEZE) begin
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_v[0] = !e_exf; m_rd[0] = id_rd; m_rw[0] = id_rw; m_ld[0] = id_ld;
    end
    if ((e_cond == HZ_STALL || e_cond == HZ_FREEZE) && m_cnt < 65535) m_cnt++;
    m_state = e_cond;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_commit();
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [25:0] exp_q[$];

  always @(negedge clk) begin
    logic [25:0] e;
    if (!rst_n) model_reset();
    model_eval();
    exp_q.push_back({e_if, e_id, e_idf, e_exf, e_fa, e_fb, 2'(m_state), 16'(m_cnt)});
    e = exp_q.pop_front();
    chk("if_en",     32'(o_if_en),        32'(e[25]));
    chk("id_en",     32'(o_id_en),        32'(e[24]));
    chk("id_flush",  32'(o_id_flush),     32'(e[23]));
    chk("ex_flush",  32'(o_ex_flush),     32'(e[22]));
    chk("forward_a", 32'(o_forward_a),    32'(e[21:20]));
    chk("forward_b", 32'(o_forward_b),    32'(e[19:18]));
    chk("state",     32'(o_state),        32'(e[17:16]));
    chk("stall_cnt", 32'(o_stall_cycles), 32'(e[15:0]));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic jal,
                     input logic redir, input logic busy);
    @(posedge clk); #1;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rw = rw; id_ld = ld;
    id_jal = jal; ex_redir = redir; dmem_busy = busy;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rw = 0; id_ld = 0; id_jal = 0; ex_redir = 0; dmem_busy = 0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    @(negedge clk); #1;
    chk("rst_state", 32'(o_state), 32'(HZ_RUN));
    chk("rst_cnt",   32'(o_stall_cycles), 32'd0);
    chk("rst_if_en", 32'(o_if_en), 32'd1);
    chk("rst_fwd_a", 32'(o_forward_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // load two ahead of its user: one stall, then WB forward
    cyc(5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0);
    cyc(5'd1, 5'd0, 5'd6, 1, 0, 0, 0, 0);
    cyc(5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 0);
    chk("lu_stall_id_en", 32'(o_id_en), 32'd0);
    chk("lu_stall_exf",   32'(o_ex_flush), 32'd1);
    cyc(5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 0);
    chk("lu_after_state", 32'(o_state), 32'(HZ_STALL));
    chk("lu_fwd_a_wb",    32'(o_forward_a), 32'd2);
    chk("lu_after_id_en", 32'(o_id_en), 32'd1);

    // load immediately ahead of its user: EX hit then MA-load hit
    idle(3);
    cyc(5'd0, 5'd0, 5'd9, 1, 1, 0, 0, 0);
    cyc(5'd9, 5'd0, 5'd2, 1, 0, 0, 0, 0);
    cyc(5'd9, 5'd0, 5'd2, 1, 0, 0, 0, 0);
    chk("lu2_second_stall", 32'(o_ex_flush), 32'd1);
    cyc(5'd9, 5'd0, 5'd2, 1, 0, 0, 0, 0);
    chk("lu2_fwd_a_wb", 32'(o_forward_a), 32'd2);

    // ALU chain, then x0 never matches
    idle(3);
    cyc(5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 0);
    cyc(5'd0, 5'd3, 5'd8, 1, 0, 0, 0, 0);
    chk("alu_stall_id_en", 32'(o_id_en), 32'd0);
    chk("alu_stall_exf",   32'(o_ex_flush), 32'd1);
    cyc(5'd0, 5'd3, 5'd8, 1, 0, 0, 0, 0);
    chk("alu_fwd_b_ma", 32'(o_forward_b), 32'd1);
    chk("alu_run_id_en", 32'(o_id_en), 32'd1);
    cyc(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    cyc(5'd0, 5'd0, 5'd9, 0, 0, 0, 0, 0);
    cyc(5'd0, 5'd0, 5'd9, 0, 0, 0, 0, 0);
    chk("x0_fwd_a", 32'(o_forward_a), 32'd0);
    chk("x0_no_stall", 32'(o_id_en), 32'd1);

    // freeze during a hazard
    do_reset();
    cyc(5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 0);
    cyc(5'd3, 5'd0, 5'd10, 1, 0, 0, 0, 1);
    chk("frz_if_en", 32'(o_if_en), 32'd0);
    chk("frz_id_en", 32'(o_id_en), 32'd0);
    chk("frz_exf",   32'(o_ex_flush), 32'd0);
    cyc(5'd3, 5'd0, 5'd10, 1, 0, 0, 0, 1);
    chk("frz_state", 32'(o_state), 32'(HZ_FREEZE));
    cyc(5'd3, 5'd0, 5'd10, 1, 0, 0, 0, 1);
    cyc(5'd3, 5'd0, 5'd10, 1, 0, 0, 0, 0);
    chk("frz_resume_exf", 32'(o_ex_flush), 32'd1);
    cyc(5'd3, 5'd0, 5'd10, 1, 0, 0, 0, 0);
    chk("frz_cnt", 32'(o_stall_cycles), 32'd4);
    chk("frz_after_fwd_a", 32'(o_forward_a), 32'd1);

    // redirect beats JAL and hazard; the shadow cycle ignores decode
    idle(3);
    cyc(5'd0, 5'd0, 5'd4, 1, 1, 0, 0, 0);
    cyc(5'd4, 5'd0, 5'd11, 1, 0, 1, 1, 0);
    chk("rd_idf", 32'(o_id_flush), 32'd1);
    chk("rd_exf", 32'(o_ex_flush), 32'd1);
    chk("rd_id_en", 32'(o_id_en), 32'd1);
    cyc(5'd4, 5'd0, 5'd11, 0, 0, 1, 0, 0);
    chk("rd_state", 32'(o_state), 32'(HZ_REDIR));
    chk("rd_shadow_idf", 32'(o_id_flush), 32'd0);
    chk("rd_shadow_exf", 32'(o_ex_flush), 32'd0);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    chk("jal_idf", 32'(o_id_flush), 32'd1);

    // reset in the middle of a stall
    idle(2);
    cyc(5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 0);
    cyc(5'd3, 5'd0, 5'd12, 1, 0, 0, 0, 0);
    chk("mrst_pre_exf", 32'(o_ex_flush), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; dmem_busy = 1'b1; ex_redir = 1'b1;
    @(negedge clk); #1;
    chk("mrst_state", 32'(o_state), 32'(HZ_RUN));
    chk("mrst_if_en", 32'(o_if_en), 32'd1);
    chk("mrst_id_en", 32'(o_id_en), 32'd1);
    chk("mrst_flush", 32'({o_id_flush, o_ex_flush}), 32'd0);
    chk("mrst_fwd",   32'({o_forward_a, o_forward_b}), 32'd0);
    chk("mrst_cnt",   32'(o_stall_cycles), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_busy = 1'b0; ex_redir = 1'b0; id_rs1 = '0;
    @(negedge clk); #1;
    chk("post_rst_id_en", 32'(o_id_en), 32'd1);

    // counter saturation
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    chk("sat_fffe", 32'(o_stall_cycles), 32'hFFFE);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    chk("sat_ffff", 32'(o_stall_cycles), 32'hFFFF);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    cyc(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    chk("sat_hold", 32'(o_stall_cycles), 32'hFFFF);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
